// File: rtl/v_issue_ctrl.sv
// Issue controller: accepts one instruction, launches its execution unit, waits for that
// unit's done flag (with timeout), then commits and counts the retirement.
module v_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        instr_valid,
  input  logic [31:0] instr_in,
  output logic        instr_ready,
  output logic [31:0] instr_out,
  input  logic [2:0]  unit_sel,
  input  logic [5:0]  done_vec,
  output logic        start,
  output logic        wb_en,
  output logic        busy,
  input  logic        err_clr,
  output logic        timeout_err,
  output logic        illegal_err,
  output logic [15:0] retired_cnt
);

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StWb} state_e;

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [2:0]  unit_q, unit_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [15:0] retired_q, retired_d;
  logic        timeout_err_q, timeout_err_d;
  logic        illegal_err_q, illegal_err_d;
  logic        unit_done;
  logic        timeout_set;
  logic        illegal_set;

  // Only the done flag of the unit captured at issue is observed.
  always_comb begin
    unit_done = 1'b0;
    case (unit_q)
      3'd1:    unit_done = done_vec[0];
      3'd2:    unit_done = done_vec[1];
      3'd3:    unit_done = done_vec[2];
      3'd4:    unit_done = done_vec[3];
      3'd5:    unit_done = done_vec[4];
      3'd6:    unit_done = done_vec[5];
      default: unit_done = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    unit_d      = unit_q;
    wait_cnt_d  = wait_cnt_q;
    retired_d   = retired_q;
    start       = 1'b0;
    wb_en       = 1'b0;
    timeout_set = 1'b0;
    illegal_set = 1'b0;
    case (state_q)
      StIdle: begin
        if (instr_valid) begin
          instr_d = instr_in;
          state_d = StIssue;
        end
      end
      StIssue: begin
        unit_d     = unit_sel;
        wait_cnt_d = 16'd0;
        if (unit_sel == 3'd7) begin
          illegal_set = 1'b1;
          state_d     = StIdle;
        end else if (unit_sel == 3'd0) begin
          state_d = StWb;
        end else begin
          start   = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        // Done takes priority over a timeout in the same cycle.
        if (unit_done) begin
          state_d = StWb;
        end else if (wait_cnt_q == TimeoutLast) begin
          timeout_set = 1'b1;
          state_d     = StIdle;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      StWb: begin
        wb_en     = (unit_q != 3'd6);
        retired_d = retired_q + 16'd1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
    timeout_err_d = timeout_set | (timeout_err_q & ~err_clr);
    illegal_err_d = illegal_set | (illegal_err_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= StIdle;
      instr_q       <= 32'd0;
      unit_q        <= 3'd0;
      wait_cnt_q    <= 16'd0;
      retired_q     <= 16'd0;
      timeout_err_q <= 1'b0;
      illegal_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      unit_q        <= unit_d;
      wait_cnt_q    <= wait_cnt_d;
      retired_q     <= retired_d;
      timeout_err_q <= timeout_err_d;
      illegal_err_q <= illegal_err_d;
    end
  end

  assign instr_ready = (state_q == StIdle);
  assign busy        = ~instr_ready;
  assign instr_out   = instr_q;
  assign timeout_err = timeout_err_q;
  assign illegal_err = illegal_err_q;
  assign retired_cnt = retired_q;

endmodule

// File: tb/tb_v_issue_ctrl.sv
// Directed bench for v_issue_ctrl with TIMEOUT_CYCLES=4; each task checks one scenario.
module tb_v_issue_ctrl;

  logic        clk;
  logic        nrst;
  logic        instr_valid;
  logic [31:0] instr_in;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [2:0]  unit_sel;
  logic [5:0]  done_vec;
  logic        start;
  logic        wb_en;
  logic        busy;
  logic        err_clr;
  logic        timeout_err;
  logic        illegal_err;
  logic [15:0] retired_cnt;

  int n_pass;
  int n_chk;
  logic [15:0] exp_ret;

  v_issue_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .instr_valid (instr_valid),
    .instr_in    (instr_in),
    .instr_ready (instr_ready),
    .instr_out   (instr_out),
    .unit_sel    (unit_sel),
    .done_vec    (done_vec),
    .start       (start),
    .wb_en       (wb_en),
    .busy        (busy),
    .err_clr     (err_clr),
    .timeout_err (timeout_err),
    .illegal_err (illegal_err),
    .retired_cnt (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    tick();
    tick();
    n_chk++; if (instr_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", instr_ready); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
    n_chk++; if ({start, wb_en} !== 2'b00) $display("FAIL rst_strobes got %b want 00", {start, wb_en}); else n_pass++;
    n_chk++; if ({timeout_err, illegal_err} !== 2'b00) $display("FAIL rst_errs got %b want 00", {timeout_err, illegal_err}); else n_pass++;
    n_chk++; if (retired_cnt !== 16'd0) $display("FAIL rst_cnt got %h want 0000", retired_cnt); else n_pass++;
    n_chk++; if (instr_out !== 32'd0) $display("FAIL rst_instr got %h want 0", instr_out); else n_pass++;
    nrst = 1'b1;
  endtask

  // Accepted on the first edge after reset release; done on the 2nd WAIT cycle.
  task automatic test_alu();
    instr_valid = 1'b1; instr_in = 32'h0220_8057; unit_sel = 3'd1;
    tick();
    instr_valid = 1'b0;
    n_chk++; if (instr_out !== 32'h0220_8057) $display("FAIL alu_instr got %h want 02208057", instr_out); else n_pass++;
    n_chk++; if (start !== 1'b1) $display("FAIL alu_start got %b want 1", start); else n_pass++;
    n_chk++; if ({instr_ready, busy} !== 2'b01) $display("FAIL alu_busy1 got %b want 01", {instr_ready, busy}); else n_pass++;
    done_vec = 6'h01;
    tick();
    done_vec = 6'h00;
    n_chk++; if ({start, wb_en} !== 2'b00) $display("FAIL alu_wait1 got %b want 00", {start, wb_en}); else n_pass++;
    tick();
    done_vec = 6'h01;
    n_chk++; if ({wb_en, instr_ready} !== 2'b00) $display("FAIL alu_wait2 got %b want 00", {wb_en, instr_ready}); else n_pass++;
    tick();
    done_vec = 6'h00;
    n_chk++; if ({start, wb_en} !== 2'b01) $display("FAIL alu_wb got %b want 01", {start, wb_en}); else n_pass++;
    n_chk++; if (instr_ready !== 1'b0) $display("FAIL alu_ready4 got %b want 0", instr_ready); else n_pass++;
    tick();
    exp_ret = 16'd1;
    n_chk++; if ({wb_en, instr_ready} !== 2'b01) $display("FAIL alu_idle got %b want 01", {wb_en, instr_ready}); else n_pass++;
    n_chk++; if (retired_cnt !== exp_ret) $display("FAIL alu_cnt got %0d want %0d", retired_cnt, exp_ret); else n_pass++;
  endtask

  // Other units' done and a changed unit_sel during WAIT are ignored; store never writes back.
  task automatic test_store();
    logic wb_seen;
    wb_seen = 1'b0;
    instr_valid = 1'b1; instr_in = 32'h0000_5027; unit_sel = 3'd6;
    tick();
    instr_valid = 1'b0;
    n_chk++; if (start !== 1'b1) $display("FAIL st_start got %b want 1", start); else n_pass++;
    wb_seen |= wb_en;
    tick();
    unit_sel = 3'd1; done_vec = 6'h01; instr_in = 32'hDEAD_BEEF;
    wb_seen |= wb_en;
    tick();
    n_chk++; if (busy !== 1'b1) $display("FAIL st_ignore_alu got busy=%b want 1", busy); else n_pass++;
    n_chk++; if (instr_out !== 32'h0000_5027) $display("FAIL st_instr_hold got %h want 00005027", instr_out); else n_pass++;
    done_vec = 6'h20;
    wb_seen |= wb_en;
    tick();
    done_vec = 6'h00;
    n_chk++; if ({busy, start} !== 2'b10) $display("FAIL st_wb got %b want 10", {busy, start}); else n_pass++;
    wb_seen |= wb_en;
    tick();
    wb_seen |= wb_en;
    exp_ret = exp_ret + 16'd1;
    n_chk++; if (wb_seen !== 1'b0) $display("FAIL st_no_wb got %b want 0", wb_seen); else n_pass++;
    n_chk++; if (retired_cnt !== exp_ret) $display("FAIL st_cnt got %0d want %0d", retired_cnt, exp_ret); else n_pass++;
    n_chk++; if (instr_ready !== 1'b1) $display("FAIL st_idle got %b want 1", instr_ready); else n_pass++;
  endtask

  task automatic test_timeout();
    logic wb_seen;
    wb_seen = 1'b0;
    instr_valid = 1'b1; unit_sel = 3'd3;
    tick();
    instr_valid = 1'b0;
    n_chk++; if (start !== 1'b1) $display("FAIL to_start got %b want 1", start); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick();
      wb_seen |= wb_en;
    end
    n_chk++; if ({busy, timeout_err} !== 2'b10) $display("FAIL to_wait4 got %b want 10", {busy, timeout_err}); else n_pass++;
    tick();
    wb_seen |= wb_en;
    n_chk++; if ({instr_ready, timeout_err} !== 2'b11) $display("FAIL to_set got %b want 11", {instr_ready, timeout_err}); else n_pass++;
    n_chk++; if (wb_seen !== 1'b0) $display("FAIL to_no_wb got %b want 0", wb_seen); else n_pass++;
    n_chk++; if (retired_cnt !== exp_ret) $display("FAIL to_cnt got %0d want %0d", retired_cnt, exp_ret); else n_pass++;
    tick();
    n_chk++; if (timeout_err !== 1'b1) $display("FAIL to_sticky got %b want 1", timeout_err); else n_pass++;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_chk++; if (timeout_err !== 1'b0) $display("FAIL to_clr got %b want 0", timeout_err); else n_pass++;
  endtask

  task automatic test_illegal_config();
    instr_valid = 1'b1; unit_sel = 3'd7;
    tick();
    instr_valid = 1'b0;
    n_chk++; if ({start, wb_en} !== 2'b00) $display("FAIL il_strobes got %b want 00", {start, wb_en}); else n_pass++;
    tick();
    n_chk++; if ({instr_ready, illegal_err} !== 2'b11) $display("FAIL il_set got %b want 11", {instr_ready, illegal_err}); else n_pass++;
    n_chk++; if (retired_cnt !== exp_ret) $display("FAIL il_cnt got %0d want %0d", retired_cnt, exp_ret); else n_pass++;
    // Config op accepted while the error flag is still set.
    instr_valid = 1'b1; unit_sel = 3'd0;
    tick();
    instr_valid = 1'b0;
    n_chk++; if ({start, wb_en, busy} !== 3'b001) $display("FAIL cf_issue got %b want 001", {start, wb_en, busy}); else n_pass++;
    tick();
    n_chk++; if ({start, wb_en} !== 2'b01) $display("FAIL cf_wb got %b want 01", {start, wb_en}); else n_pass++;
    tick();
    exp_ret = exp_ret + 16'd1;
    n_chk++; if (retired_cnt !== exp_ret) $display("FAIL cf_cnt got %0d want %0d", retired_cnt, exp_ret); else n_pass++;
    n_chk++; if ({instr_ready, illegal_err} !== 2'b11) $display("FAIL cf_idle got %b want 11", {instr_ready, illegal_err}); else n_pass++;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_chk++; if (illegal_err !== 1'b0) $display("FAIL il_clr got %b want 0", illegal_err); else n_pass++;
    // Set beats clear in the same cycle.
    instr_valid = 1'b1; unit_sel = 3'd7;
    tick();
    instr_valid = 1'b0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_chk++; if (illegal_err !== 1'b1) $display("FAIL il_set_wins got %b want 1", illegal_err); else n_pass++;
  endtask

  task automatic test_async_reset();
    logic wb_seen;
    wb_seen = 1'b0;
    instr_valid = 1'b1; instr_in = 32'h1234_5678; unit_sel = 3'd2;
    tick();
    instr_valid = 1'b0;
    tick();
    #2 nrst = 1'b0;
    #1;
    n_chk++; if ({instr_ready, busy} !== 2'b10) $display("FAIL ar_ready got %b want 10", {instr_ready, busy}); else n_pass++;
    n_chk++; if (instr_out !== 32'd0) $display("FAIL ar_instr got %h want 0", instr_out); else n_pass++;
    n_chk++; if ({illegal_err, timeout_err, start, wb_en} !== 4'b0000) $display("FAIL ar_flags got %b want 0000", {illegal_err, timeout_err, start, wb_en}); else n_pass++;
    n_chk++; if (retired_cnt !== 16'd0) $display("FAIL ar_cnt got %0d want 0", retired_cnt); else n_pass++;
    #1 nrst = 1'b1;
    done_vec = 6'h02;
    for (int i = 0; i < 3; i++) begin
      tick();
      wb_seen |= wb_en;
    end
    done_vec = 6'h00;
    exp_ret = 16'd0;
    n_chk++; if ({wb_seen, instr_ready} !== 2'b01) $display("FAIL ar_post_done got %b want 01", {wb_seen, instr_ready}); else n_pass++;
    n_chk++; if (retired_cnt !== exp_ret) $display("FAIL ar_post_cnt got %0d want 0", retired_cnt); else n_pass++;
  endtask

  // Done arrives exactly on the last allowed WAIT cycle.
  task automatic test_done_timeout_tie();
    instr_valid = 1'b1; unit_sel = 3'd4;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    tick();
    tick();
    done_vec = 6'h08;
    tick();
    done_vec = 6'h00;
    n_chk++; if ({wb_en, timeout_err} !== 2'b10) $display("FAIL tie_wb got %b want 10", {wb_en, timeout_err}); else n_pass++;
    tick();
    exp_ret = exp_ret + 16'd1;
    n_chk++; if ({instr_ready, timeout_err} !== 2'b10) $display("FAIL tie_idle got %b want 10", {instr_ready, timeout_err}); else n_pass++;
    n_chk++; if (retired_cnt !== exp_ret) $display("FAIL tie_cnt got %0d want %0d", retired_cnt, exp_ret); else n_pass++;
  endtask

  task automatic test_wrap();
    force dut.retired_q = 16'hFFFF;
    #1 release dut.retired_q;
    instr_valid = 1'b1; unit_sel = 3'd0;
    tick();
    instr_valid = 1'b0;
    tick();
    n_chk++; if (wb_en !== 1'b1) $display("FAIL wrap_wb got %b want 1", wb_en); else n_pass++;
    tick();
    n_chk++; if (retired_cnt !== 16'h0000) $display("FAIL wrap_cnt got %h want 0000", retired_cnt); else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_chk = 0;
    exp_ret = 16'd0;
    nrst = 1'b0;
    instr_valid = 1'b0;
    instr_in = 32'd0;
    unit_sel = 3'd0;
    done_vec = 6'h00;
    err_clr = 1'b0;
    test_reset();
    test_alu();
    test_store();
    test_timeout();
    test_illegal_config();
    test_async_reset();
    test_done_timeout_tie();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
